// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit with a single-cycle multiplier and a
// 32-step restoring divider; results and status are registered.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ex_sig,
  input  logic [31:0] ex_src1,
  input  logic [31:0] ex_src2,
  input  logic        ex_out_valid,
  output logic [31:0] ex_result,
  output logic [2:0]  ex_exception,
  output logic        ex_in_valid,
  output logic        ex_busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, nxt;
  logic [5:0] cnt;
  logic [2:0] f3;
  logic [31:0] a, b, q, r, mag1, mag2, mul_res, fix_res;
  logic spec, qneg, rneg, ill, acc, sgn, zero, ovf;
  logic [63:0] prod;
  logic [32:0] t, dif;
  assign acc = state == IDLE && ex_out_valid;
  assign sgn = ~ex_sig[0];
  assign zero = ex_src2 == 32'd0;
  assign ovf = sgn && ex_src1 == 32'h8000_0000 && ex_src2 == 32'hFFFF_FFFF;
  assign mag1 = (sgn && ex_src1[31]) ? -ex_src1 : ex_src1;
  assign mag2 = (sgn && ex_src2[31]) ? -ex_src2 : ex_src2;
  assign ex_busy = state != IDLE;
  // Sign-extend to 64 bits so a plain 64x64 product gives every signedness mix
  assign prod = {{32{(f3[1:0] == 2'd1 || f3[1:0] == 2'd2) && a[31]}}, a}
              * {{32{f3[1:0] == 2'd1 && b[31]}}, b};
  assign mul_res = f3[1:0] == 2'd0 ? prod[31:0] : prod[63:32];
  assign t = {r, q[31]};
  assign dif = t - {1'b0, b};
  assign fix_res = spec ? q : f3[1] ? (rneg ? -r : r) : (qneg ? -q : q);
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc && ex_sig[3]) nxt = !ex_sig[2] ? MUL : (zero || ovf) ? FIX : DIV;
      MUL:  nxt = IDLE;
      DIV:  nxt = cnt == 6'd31 ? FIX : DIV;
      FIX:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {cnt, f3, a, b, q, r, spec, qneg, rneg, ill} <= '0;
      {ex_result, ex_exception, ex_in_valid} <= '0;
    end else begin
      ex_in_valid <= 1'b0;
      ill <= 1'b0;
      if (acc) begin
        f3 <= ex_sig[2:0];
        a <= ex_src1;
        b <= ex_sig[2] ? mag2 : ex_src2;
        cnt <= '0;
        r <= '0;
        ill <= ~ex_sig[3];
        spec <= zero || ovf;
        qneg <= sgn && (ex_src1[31] ^ ex_src2[31]);
        rneg <= sgn && ex_src1[31];
        q <= zero ? (ex_sig[1] ? ex_src1 : 32'hFFFF_FFFF)
           : ovf ? (ex_sig[1] ? 32'd0 : 32'h8000_0000) : mag1;
      end
      if (ill) {ex_result, ex_exception, ex_in_valid} <= {32'd0, 3'd2, 1'b1};
      if (state == MUL) {ex_result, ex_exception, ex_in_valid} <= {mul_res, 3'd0, 1'b1};
      if (state == DIV) begin
        r <= dif[32] ? t[31:0] : dif[31:0];
        q <= {q[30:0], ~dif[32]};
        cnt <= cnt + 6'd1;
      end
      if (state == FIX) {ex_result, ex_exception, ex_in_valid} <= {fix_res, 3'd0, 1'b1};
    end
  end
endmodule
